decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: instruction buffer with a registered MIPS decode stage.
// A DEPTH-entry circular FIFO of {instr, pc} feeds one output register that
// holds the decoded fields of the oldest instruction.
// Optional feature macro: DECODE_QUEUE_TRAP_EN enables decoding of the
// conditional trap instructions (SPECIAL funct 110xxx, REGIMM rt 01xxx).
// When it is undefined those encodings decode as reserved and trap stays 0.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its data until it sees ready.
// in_ready depends only on registered occupancy. It does not rise early
// because of a pop in the same cycle. out_* fields hold steady while out_valid
// is high and out_ready is low.
module decode_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [5:0]      out_op,
   output logic [5:0]      out_func,
   output logic [5:0]      out_waddr,
   output logic [5:0]      out_raddr1,
   output logic [5:0]      out_raddr2,
   output logic [25:0]     out_imm,
   output logic [10:0]     out_flags,
   output logic            out_reserved,
   output logic [4:0]      count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [5:0] OP_SPECIAL  = 6'h00;
   localparam logic [5:0] OP_REGIMM   = 6'h01;
   localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

   typedef struct packed {
      logic [5:0]  op;
      logic [5:0]  func;
      logic [5:0]  waddr;
      logic [5:0]  raddr1;
      logic [5:0]  raddr2;
      logic [25:0] imm;
      logic [10:0] flags;
      logic        reserved;
   } dec_t;

   // Decode one raw instruction word into the output-stage fields.
   // Flag order: {shamt, sext, jump, branch, load, store, mult, div, jal, trap, unsigned}.
   // jal marks every linking jump (JAL and JALR). mult also covers SPECIAL2 MUL.
   function automatic dec_t decode(input logic [31:0] instr);
      dec_t       d;
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       legal;
      logic       wr_rd;
      logic       wr_rt;
      logic       wr_ra;
      logic       use_rs;
      logic       use_rt;
      logic       use_i16;
      logic       use_tgt;
      logic       f_shamt;
      logic       f_sext;
      logic       f_jump;
      logic       f_branch;
      logic       f_load;
      logic       f_store;
      logic       f_mult;
      logic       f_div;
      logic       f_jal;
      logic       f_trap;
      logic       f_uns;

      op       = instr[31:26];
      fn       = instr[5:0];
      rs       = instr[25:21];
      rt       = instr[20:16];
      rd       = instr[15:11];
      d        = '0;
      legal    = 1'b0;
      wr_rd    = 1'b0;
      wr_rt    = 1'b0;
      wr_ra    = 1'b0;
      use_rs   = 1'b0;
      use_rt   = 1'b0;
      use_i16  = 1'b0;
      use_tgt  = 1'b0;
      f_shamt  = 1'b0;
      f_sext   = 1'b0;
      f_jump   = 1'b0;
      f_branch = 1'b0;
      f_load   = 1'b0;
      f_store  = 1'b0;
      f_mult   = 1'b0;
      f_div    = 1'b0;
      f_jal    = 1'b0;
      f_trap   = 1'b0;
      f_uns    = 1'b0;

      case (op)
         OP_SPECIAL: begin
            casez (fn)
               6'h00, 6'h02, 6'h03: begin            // SLL SRL SRA
                  legal = 1'b1; wr_rd = 1'b1; use_rt = 1'b1; f_shamt = 1'b1;
               end
               6'h04, 6'h06, 6'h07,                  // variable shifts
               6'b100???, 6'h2A, 6'h2B: begin        // ALU, SLT, SLTU
                  legal = 1'b1; wr_rd = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
               end
               6'h08: begin                          // JR
                  legal = 1'b1; use_rs = 1'b1; f_jump = 1'b1;
               end
               6'h09: begin                          // JALR
                  legal = 1'b1; wr_rd = 1'b1; use_rs = 1'b1; f_jump = 1'b1; f_jal = 1'b1;
               end
               6'h0C, 6'h0D: begin                   // SYSCALL BREAK
                  legal = 1'b1; use_rt = 1'b1;
               end
               6'h10, 6'h12: begin                   // MFHI MFLO
                  legal = 1'b1; wr_rd = 1'b1; use_rt = 1'b1;
               end
               6'h11, 6'h13: begin                   // MTHI MTLO
                  legal = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
               end
               6'b0110??: begin                      // MULT MULTU DIV DIVU
                  legal = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
                  f_mult = ~fn[1]; f_div = fn[1]; f_uns = fn[0];
               end
`ifdef DECODE_QUEUE_TRAP_EN
               6'b110???: begin                      // TGE..TNE
                  legal = 1'b1; use_rs = 1'b1; use_rt = 1'b1; f_trap = 1'b1;
               end
`endif
               default: ;
            endcase
         end
         OP_REGIMM: begin
            casez (rt)
               5'b0000?: begin                       // BLTZ BGEZ
                  legal = 1'b1; use_rs = 1'b1; use_i16 = 1'b1; f_sext = 1'b1; f_branch = 1'b1;
               end
`ifdef DECODE_QUEUE_TRAP_EN
               5'b01???: begin                       // TGEI..TNEI
                  legal = 1'b1; use_rs = 1'b1; use_i16 = 1'b1; f_sext = 1'b1; f_trap = 1'b1;
               end
`endif
               default: ;
            endcase
         end
         6'h02: begin                                // J
            legal = 1'b1; use_tgt = 1'b1; f_jump = 1'b1;
         end
         6'h03: begin                                // JAL links into r31
            legal = 1'b1; use_tgt = 1'b1; f_jump = 1'b1; f_jal = 1'b1; wr_ra = 1'b1;
         end
         6'h04, 6'h05: begin                         // BEQ BNE
            legal = 1'b1; use_rs = 1'b1; use_rt = 1'b1; use_i16 = 1'b1;
            f_sext = 1'b1; f_branch = 1'b1;
         end
         6'h06, 6'h07: begin                         // BLEZ BGTZ
            legal = 1'b1; use_rs = 1'b1; use_i16 = 1'b1; f_sext = 1'b1; f_branch = 1'b1;
         end
         6'h08, 6'h09, 6'h0A, 6'h0B: begin           // ADDI ADDIU SLTI SLTIU
            legal = 1'b1; wr_rt = 1'b1; use_rs = 1'b1; use_i16 = 1'b1; f_sext = 1'b1;
         end
         6'h0C, 6'h0D, 6'h0E: begin                  // ANDI ORI XORI
            legal = 1'b1; wr_rt = 1'b1; use_rs = 1'b1; use_i16 = 1'b1;
         end
         6'h0F: begin                                // LUI
            legal = 1'b1; wr_rt = 1'b1; use_i16 = 1'b1;
         end
         OP_SPECIAL2: begin
            if (fn == 6'h02) begin                   // MUL
               legal = 1'b1; wr_rd = 1'b1; use_rs = 1'b1; use_rt = 1'b1; f_mult = 1'b1;
            end
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin    // LB LH LW LBU LHU
            legal = 1'b1; wr_rt = 1'b1; use_rs = 1'b1; use_i16 = 1'b1;
            f_sext = 1'b1; f_load = 1'b1; f_uns = op[2];
         end
         6'h28, 6'h29, 6'h2B: begin                  // SB SH SW
            legal = 1'b1; use_rs = 1'b1; use_rt = 1'b1; use_i16 = 1'b1;
            f_sext = 1'b1; f_store = 1'b1;
         end
         default: ;
      endcase

      d.op   = op;
      d.func = (op == OP_SPECIAL || op == OP_SPECIAL2) ? fn : 6'd0;
      if (legal) begin
         d.waddr  = wr_rd ? {1'b1, rd} : (wr_rt ? {1'b1, rt} : (wr_ra ? 6'h3F : 6'h00));
         d.raddr1 = use_rs ? {1'b1, rs} : 6'h00;
         d.raddr2 = use_rt ? {1'b1, rt} : 6'h00;
         if (f_shamt) begin
            d.imm = {21'd0, instr[10:6]};
         end else if (use_tgt) begin
            d.imm = instr[25:0];
         end else if (use_i16) begin
            d.imm = f_sext ? {{10{instr[15]}}, instr[15:0]} : {10'd0, instr[15:0]};
         end
         d.flags = {f_shamt, f_sext, f_jump, f_branch, f_load, f_store,
                    f_mult, f_div, f_jal, f_trap, f_uns};
      end else begin
         d.reserved = 1'b1;
      end
      return d;
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   logic [31:0]     mem_instr_q [DEPTH];
   logic [PC_W-1:0] mem_pc_q    [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic             out_valid_q, out_valid_d;
   logic [PC_W-1:0]  out_pc_q, out_pc_d;
   dec_t             dec_q, dec_d;

   logic push;
   logic pop;
   logic out_load;
   logic fifo_empty;
   logic head_take;
   logic bypass;
   logic fifo_wr;

   assign in_ready   = (fcnt_q < CNT_W'(DEPTH));
   assign push       = in_valid && in_ready && !flush;
   assign pop        = out_valid_q && out_ready;
   assign out_load   = !out_valid_q || pop;
   assign fifo_empty = (fcnt_q == '0);
   // The output register pulls from the FIFO head whenever it has room.
   // With an empty FIFO a new push skips storage and decodes straight in.
   assign head_take  = out_load && !fifo_empty;
   assign bypass     = out_load && fifo_empty && push;
   assign fifo_wr    = push && !bypass;

   // Next-state for pointers, occupancy and the decoded output stage. flush wins.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fcnt_d      = fcnt_q;
      out_valid_d = out_valid_q;
      out_pc_d    = out_pc_q;
      dec_d       = dec_q;
      if (fifo_wr) begin
         wr_ptr_d = next_ptr(wr_ptr_q);
      end
      if (head_take) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({fifo_wr, head_take})
         2'b10:   fcnt_d = fcnt_q + CNT_W'(1);
         2'b01:   fcnt_d = fcnt_q - CNT_W'(1);
         default: ;
      endcase
      if (out_load) begin
         out_valid_d = head_take || bypass;
         if (head_take) begin
            dec_d    = decode(mem_instr_q[rd_ptr_q]);
            out_pc_d = mem_pc_q[rd_ptr_q];
         end else if (bypass) begin
            dec_d    = decode(in_instr);
            out_pc_d = in_pc;
         end
      end
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         fcnt_d      = '0;
         out_valid_d = 1'b0;
      end
   end

   // Control and output-stage registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fcnt_q      <= '0;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         dec_q       <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fcnt_q      <= fcnt_d;
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         dec_q       <= dec_d;
      end
   end

   // FIFO storage; contents need no reset because occupancy guards every read.
   always_ff @(posedge clk) begin
      if (fifo_wr && !reset) begin
         mem_instr_q[wr_ptr_q] <= in_instr;
         mem_pc_q[wr_ptr_q]    <= in_pc;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_pc       = out_pc_q;
   assign out_op       = dec_q.op;
   assign out_func     = dec_q.func;
   assign out_waddr    = dec_q.waddr;
   assign out_raddr1   = dec_q.raddr1;
   assign out_raddr2   = dec_q.raddr2;
   assign out_imm      = dec_q.imm;
   assign out_flags    = dec_q.flags;
   assign out_reserved = dec_q.reserved;
   assign count        = 5'(fcnt_q) + 5'(out_valid_q);

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed steps followed by random traffic for decode_queue.
// The model is a queue of every held {pc, instr}. Its front is the presented
// instruction. Expected decode fields come from a reference classifier.
module tb_decode_queue;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;

   localparam int F_SH = 10, F_SX = 9, F_J = 8, F_BR = 7, F_LD = 6, F_ST = 5;
   localparam int F_MU = 4, F_DV = 3, F_JAL = 2, F_TR = 1, F_UN = 0;

   typedef struct packed {
      logic [5:0]  op;
      logic [5:0]  func;
      logic [5:0]  waddr;
      logic [5:0]  raddr1;
      logic [5:0]  raddr2;
      logic [25:0] imm;
      logic [10:0] flags;
      logic        rsv;
   } exp_t;

   logic            clk;
   logic            reset;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [5:0]      out_op;
   logic [5:0]      out_func;
   logic [5:0]      out_waddr;
   logic [5:0]      out_raddr1;
   logic [5:0]      out_raddr2;
   logic [25:0]     out_imm;
   logic [10:0]     out_flags;
   logic            out_reserved;
   logic [4:0]      count;

   logic [63:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;

   decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_op       (out_op),
      .out_func     (out_func),
      .out_waddr    (out_waddr),
      .out_raddr1   (out_raddr1),
      .out_raddr2   (out_raddr2),
      .out_imm      (out_imm),
      .out_flags    (out_flags),
      .out_reserved (out_reserved),
      .count        (count)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   // Reference decoder: classify by mnemonic group, then build the fields.
   function automatic exp_t ref_decode(input logic [31:0] w);
      exp_t        e;
      int          op, fn, rt, rd;
      bit          ok, r1, r2, i16, trap_ok;
      int          wreg;
      logic [10:0] fl;
      e   = '0;
      op  = int'(w[31:26]);
      fn  = int'(w[5:0]);
      rt  = int'(w[20:16]);
      rd  = int'(w[15:11]);
      ok  = 0; r1 = 0; r2 = 0; i16 = 0; wreg = -1; fl = '0;
`ifdef DECODE_QUEUE_TRAP_EN
      trap_ok = 1;
`else
      trap_ok = 0;
`endif
      if (op == 0) begin
         if (fn inside {0, 2, 3}) begin
            ok = 1; wreg = rd; r2 = 1; fl[F_SH] = 1; e.imm = {21'd0, w[10:6]};
         end else if (fn inside {4, 6, 7, [32:39], 42, 43}) begin
            ok = 1; wreg = rd; r1 = 1; r2 = 1;
         end else if (fn == 8) begin
            ok = 1; r1 = 1; fl[F_J] = 1;
         end else if (fn == 9) begin
            ok = 1; wreg = rd; r1 = 1; fl[F_J] = 1; fl[F_JAL] = 1;
         end else if (fn inside {12, 13}) begin
            ok = 1; r2 = 1;
         end else if (fn inside {16, 18}) begin
            ok = 1; wreg = rd; r2 = 1;
         end else if (fn inside {17, 19}) begin
            ok = 1; r1 = 1; r2 = 1;
         end else if (fn >= 24 && fn <= 27) begin
            ok = 1; r1 = 1; r2 = 1;
            fl[F_MU] = (fn < 26); fl[F_DV] = (fn >= 26); fl[F_UN] = (fn % 2 == 1);
         end else if (fn >= 48 && fn <= 55 && trap_ok) begin
            ok = 1; r1 = 1; r2 = 1; fl[F_TR] = 1;
         end
      end else if (op == 1) begin
         if (rt <= 1) begin
            ok = 1; r1 = 1; i16 = 1; fl[F_BR] = 1; fl[F_SX] = 1;
         end else if (rt >= 8 && rt <= 15 && trap_ok) begin
            ok = 1; r1 = 1; i16 = 1; fl[F_TR] = 1; fl[F_SX] = 1;
         end
      end else if (op == 2 || op == 3) begin
         ok = 1; fl[F_J] = 1; e.imm = w[25:0];
         if (op == 3) begin
            wreg = 31; fl[F_JAL] = 1;
         end
      end else if (op >= 4 && op <= 7) begin
         ok = 1; r1 = 1; r2 = (op < 6); i16 = 1; fl[F_BR] = 1; fl[F_SX] = 1;
      end else if (op >= 8 && op <= 15) begin
         ok = 1; wreg = rt; r1 = (op != 15); i16 = 1; fl[F_SX] = (op < 12);
      end else if (op == 28 && fn == 2) begin
         ok = 1; wreg = rd; r1 = 1; r2 = 1; fl[F_MU] = 1;
      end else if (op inside {32, 33, 35, 36, 37}) begin
         ok = 1; wreg = rt; r1 = 1; i16 = 1; fl[F_LD] = 1; fl[F_SX] = 1; fl[F_UN] = (op >= 36);
      end else if (op inside {40, 41, 43}) begin
         ok = 1; r1 = 1; r2 = 1; i16 = 1; fl[F_ST] = 1; fl[F_SX] = 1;
      end
      e.op   = w[31:26];
      e.func = (op == 0 || op == 28) ? w[5:0] : 6'd0;
      if (!ok) begin
         e.imm = '0;
         e.rsv = 1'b1;
         return e;
      end
      if (i16) e.imm = fl[F_SX] ? {{10{w[15]}}, w[15:0]} : {10'd0, w[15:0]};
      if (wreg >= 0) e.waddr = {1'b1, 5'(wreg)};
      if (r1) e.raddr1 = {1'b1, w[25:21]};
      if (r2) e.raddr2 = {1'b1, w[20:16]};
      e.flags = fl;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom();
      case ($urandom_range(0, 4))
         0: w[31:26] = 6'h00;
         1: begin
            w[31:26] = 6'h01;
            w[20:16] = 5'($urandom_range(0, 15));
         end
         2: begin
            case ($urandom_range(0, 7))
               0:       w[31:26] = 6'h02;
               1:       w[31:26] = 6'h03;
               2:       w[31:26] = 6'h04;
               3:       w[31:26] = 6'h07;
               4:       w[31:26] = 6'h09;
               5:       w[31:26] = 6'h0F;
               6:       w[31:26] = 6'h24;
               default: w[31:26] = 6'h2B;
            endcase
         end
         3: begin
            w[31:26] = 6'h1C;
            w[5:0]   = 6'($urandom_range(0, 3));
         end
         default: ;
      endcase
      return w;
   endfunction

   function automatic int model_occ();
      return (exp_q.size() > 0) ? exp_q.size() - 1 : 0;
   endfunction

   // Scoreboard comparison.
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      exp_t e;
      int   n;
      n = exp_q.size();
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(n > 0));
      chk({tag, ".count"},     64'(count),     64'(n));
      chk({tag, ".in_ready"},  64'(in_ready),  64'(model_occ() < DEPTH));
      if (n > 0) begin
         e = ref_decode(exp_q[0][31:0]);
         chk({tag, ".pc"},       64'(out_pc),       64'(exp_q[0][63:32]));
         chk({tag, ".op"},       64'(out_op),       64'(e.op));
         chk({tag, ".func"},     64'(out_func),     64'(e.func));
         chk({tag, ".waddr"},    64'(out_waddr),    64'(e.waddr));
         chk({tag, ".raddr1"},   64'(out_raddr1),   64'(e.raddr1));
         chk({tag, ".raddr2"},   64'(out_raddr2),   64'(e.raddr2));
         chk({tag, ".imm"},      64'(out_imm),      64'(e.imm));
         chk({tag, ".flags"},    64'(out_flags),    64'(e.flags));
         chk({tag, ".reserved"}, 64'(out_reserved), 64'(e.rsv));
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".pc"},       64'(out_pc),       64'd0);
      chk({tag, ".op"},       64'(out_op),       64'd0);
      chk({tag, ".func"},     64'(out_func),     64'd0);
      chk({tag, ".waddr"},    64'(out_waddr),    64'd0);
      chk({tag, ".raddr1"},   64'(out_raddr1),   64'd0);
      chk({tag, ".raddr2"},   64'(out_raddr2),   64'd0);
      chk({tag, ".imm"},      64'(out_imm),      64'd0);
      chk({tag, ".flags"},    64'(out_flags),    64'd0);
      chk({tag, ".reserved"}, 64'(out_reserved), 64'd0);
   endtask

   // Driver: one clock edge with model update, then check after the edge.
   task automatic tick();
      bit acc;
      bit pv;
      acc = in_valid && (model_occ() < DEPTH);
      pv  = (exp_q.size() != 0) && out_ready;
      @(posedge clk);
      if (reset || flush) begin
         exp_q.delete();
      end else begin
         if (pv) void'(exp_q.pop_front());
         if (acc) exp_q.push_back({in_pc, in_instr});
      end
      #1;
      check_all("cyc");
   endtask

   task automatic drain(input string tag);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick();
      chk({tag, ".drained"}, 64'(count), 64'd0);
   endtask

   initial begin
      logic [31:0]     seq_instr [6];
      logic [PC_W-1:0] next_pc;
      logic [PC_W-1:0] pop_pc;
      bit              acc;

      seq_instr[0] = 32'h00221820;   // ADD r3,r1,r2
      seq_instr[1] = 32'h8C850008;   // LW r5,8(r4)
      seq_instr[2] = 32'hACE6FFFC;   // SW r6,-4(r7)
      seq_instr[3] = 32'h10220003;   // BEQ r1,r2,+3
      seq_instr[4] = 32'h08123456;   // J
      seq_instr[5] = 32'h0C000010;   // JAL

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check_zero("reset");
      tick();
      chk("reset.in_ready", 64'(in_ready), 64'd1);

      // Single ADDI into an empty queue: visible one edge later.
      in_valid = 1'b1; in_instr = 32'h2022FFFF; in_pc = 32'h100;
      tick();
      in_valid = 1'b0;
      chk("addi.out_valid", 64'(out_valid), 64'd1);
      chk("addi.waddr",     64'(out_waddr),  64'h22);
      chk("addi.raddr1",    64'(out_raddr1), 64'h21);
      chk("addi.imm",       64'(out_imm),    64'h3FFFFFF);
      chk("addi.sext",      64'(out_flags[F_SX]), 64'd1);
      out_ready = 1'b1;
      tick();

      // Stalled consumer, six offers: five held, the sixth refused.
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_instr = seq_instr[i]; in_pc = 32'h200 + 32'(4 * i);
         tick();
         if (i == 3) chk("fill4.in_ready", 64'(in_ready), 64'd1);
         if (i == 4) chk("fill5.in_ready", 64'(in_ready), 64'd0);
         chk("fill.hold_pc", 64'(out_pc), 64'h200);
      end
      chk("fill.count", 64'(count), 64'd5);
      chk("fill.op", 64'(out_op), 64'h00);
      chk("fill.waddr", 64'(out_waddr), 64'h23);

      // Full queue, both sides active for ten cycles: order and pointer wrap.
      next_pc = 32'h214;
      pop_pc  = 32'h200;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_pc    = next_pc;
         in_instr = seq_instr[i % 6];
         acc      = (model_occ() < DEPTH);
         if (out_valid && out_ready) begin
            chk("stream.pop_order", 64'(out_pc), 64'(pop_pc));
            pop_pc = pop_pc + 32'd4;
         end
         tick();
         if (acc) next_pc = next_pc + 32'd4;
      end
      chk("stream.count", 64'(count), 64'd4);
      chk("stream.next_out", 64'(out_pc), 64'h228);
      drain("stream");

      // Flush with an offer in the same cycle: offer is dropped.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_instr = seq_instr[i]; in_pc = 32'h300 + 32'(4 * i);
         tick();
      end
      chk("flush.pre_count", 64'(count), 64'd3);
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h2022FFFF; in_pc = 32'hDEAD0000; out_ready = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush.count", 64'(count), 64'd0);
      chk("flush.out_valid", 64'(out_valid), 64'd0);
      in_valid = 1'b1; in_instr = seq_instr[4]; in_pc = 32'h400; out_ready = 1'b0;
      tick();
      chk("flush.after_pc", 64'(out_pc), 64'h400);
      drain("flush");

      // TEQ r1,r2.
      in_valid = 1'b1; in_instr = 32'h00220034; in_pc = 32'h500; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
`ifdef DECODE_QUEUE_TRAP_EN
      chk("teq.trap",   64'(out_flags[F_TR]), 64'd1);
      chk("teq.raddr1", 64'(out_raddr1), 64'h21);
      chk("teq.raddr2", 64'(out_raddr2), 64'h22);
`else
      chk("teq.reserved", 64'(out_reserved), 64'd1);
      chk("teq.flags",    64'(out_flags), 64'd0);
`endif
      drain("teq");

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 99) < 70);
         out_ready = ($urandom_range(0, 99) < 60);
         flush     = ($urandom_range(0, 49) == 0);
         reset     = ($urandom_range(0, 199) == 0);
         in_instr  = rand_instr();
         in_pc     = $urandom();
         tick();
      end
      flush = 1'b0;

      // Reset in the middle of traffic.
      in_valid = 1'b1; out_ready = 1'b0; in_instr = seq_instr[1];
      for (int i = 0; i < 3; i++) begin
         in_pc = 32'h600 + 32'(4 * i);
         tick();
      end
      reset = 1'b1; in_valid = 1'b1;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      check_zero("midreset");
      chk("midreset.in_ready", 64'(in_ready), 64'd1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
